pingpong_fill_ctrl: RTL
=======================

# pingpong_fill_ctrl

Write-side controller for the ECG ping-pong sample buffer. Accepts a stream of 32-bit analysed samples and produces the fill-port address, data and write strobe, and the bank-select `switch` consumed by `switching_block`. When a bank holds a complete frame, it hands that bank to the reader through a ready/done handshake. It never swaps banks while the reader still owns the other bank.

## Interface
- `ADDR_W`, 12, fill address width (matches BRAM depth 4096)
- `DATA_W`, 32, sample width
- `FRAME_LEN`, 2500, samples per frame; legal range 2..2**ADDR_W
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  input sample valid
- `s_data`  in  DATA_W  input sample
- `s_ready`  out  1  sample accepted on `s_valid & s_ready`
- `fu_addra`  out  ADDR_W  fill-port address
- `dt_an`  out  DATA_W  fill-port write data
- `fu_we`  out  1  fill-port write strobe
- `switch`  out  1  bank select; 0 means the writer fills bank 2 and the reader owns bank 1
- `frame_ready`  out  1  level; the reader owns a complete bank
- `frame_done`  in  1  one-cycle pulse from the reader; releases its bank
- `frame_cnt`  out  16  frames handed over, wraps
- `overflow`  out  1  sticky; a sample was dropped (see Configuration)

## Operation
- Reset values: `s_ready`=0, `fu_addra`=0, `dt_an`=0, `fu_we`=0, `switch`=0, `frame_ready`=0, `frame_cnt`=0, `overflow`=0. State goes to FILL one cycle after reset release.
- Internal `rd_busy` drives `frame_ready`. It sets on every swap and clears on `frame_done`.
- States:
  - FILL: `s_ready`=1. Each accept writes the sample at the current address and increments the address. The accept at address FRAME_LEN-1 goes to SWAP.
  - SWAP: one cycle, `s_ready`=0, lets the last write land in the current bank. The swap happens if `rd_busy`=0 or `frame_done`=1 in this cycle; otherwise go to HOLD.
  - HOLD: the bank is full and the reader is busy. On `frame_done`, swap and go to FILL.
- Swap action, all at one clock edge:
  - toggle `switch`
  - address ← 0
  - `rd_busy` ← 1
  - `frame_cnt` ← `frame_cnt` + 1 (mod 2^16)
- `frame_done` while `rd_busy`=0 is ignored.
- `frame_done` coinciding with a swap edge means release and re-acquire: the swap proceeds and `rd_busy` stays 1.
- The address counter is ADDR_W wide and never exceeds FRAME_LEN-1.
- Reset asserted mid-frame discards the partial frame. All outputs return to their reset values asynchronously.

## Timing
- `s_ready` is a combinational decode of state.
- `fu_addra`, `dt_an` and `fu_we` are registered: an accept at edge k gives `fu_we`=1 during cycle k→k+1.
- `switch` changes only at the SWAP/HOLD exit edge. `fu_we` is 0 in every cycle in which `switch` differs from its previous value.
- Minimum frame period is FRAME_LEN+1 cycles, with zero-wait-state input and an idle reader.
- `frame_ready` rises the cycle after the swap edge. It falls the cycle after `frame_done`, unless a swap occurs on that same edge.

## Configuration
- `PINGPONG_DROP_EN` defined:
  - In HOLD, `s_ready`=1.
  - Accepted samples are discarded: no write, address held.
  - `overflow` sets and stays set until reset.
- `PINGPONG_DROP_EN` undefined:
  - In HOLD, `s_ready`=0 (backpressure).
  - `overflow` is tied to 0.

## Structure
- Shared package `pingpong_pkg` holds:
  - state enum {FILL, SWAP, HOLD}
  - default `ADDR_W` and `DATA_W` localparams
  - `FRAME_CNT_W`=16
- One natural sub-module, `pp_addr_counter`:
  - inputs: increment, clear
  - outputs: `at_last` flag and address
  - parameterised by `FRAME_LEN`

## Test plan
- Reset then 4 accepts, FRAME_LEN=4, reader idle: writes at addresses 0..3 on bank 2. `switch` goes 0→1 one cycle after the addr-3 write. `frame_ready`=1, `frame_cnt`=1.
- 8 continuous samples, reader never sends `frame_done`, no macro: the second bank fills and the controller enters HOLD with `s_ready`=0 and `switch` still 1. A `frame_done` pulse gives `switch`=0 and `frame_cnt`=2.
- Same as the previous case, macro defined: in HOLD, 3 samples are accepted and no `fu_we` is asserted. `overflow`=1 and stays 1 after a later swap.
- `frame_done` on the same cycle as SWAP with `rd_busy`=1: the swap occurs, `frame_ready` stays 1 with no dropout, and the controller does not enter HOLD.
- `rst_n` pulsed low after 2 of 4 samples: all outputs go to their reset values immediately, and the next frame starts at address 0 with `switch`=0.
- `frame_done` while `frame_ready`=0: no state change, and `frame_cnt` is unchanged.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared types and defaults for the ECG ping-pong buffer write side.
// The optional sample-drop behaviour is selected with the PINGPONG_DROP_EN macro.
package pingpong_pkg;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_FRAME_LEN = 2500;
  localparam int FRAME_CNT_W   = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SWAP = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/pp_addr_counter.sv
// Fill address counter for one bank: counts 0..FRAME_LEN-1, saturates at the
// last address and flags it, and is cleared when the banks swap.
module pp_addr_counter
  import pingpong_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  assign at_last = (addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc && !at_last) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/pingpong_fill_ctrl.sv
// Write-side controller for the ECG ping-pong sample buffer.
// Define PINGPONG_DROP_EN to accept-and-discard samples while waiting for the reader.
module pingpong_fill_ctrl
  import pingpong_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic [ADDR_W-1:0]      fu_addra,
  output logic [DATA_W-1:0]      dt_an,
  output logic                   fu_we,
  output logic                   switch,
  output logic                   frame_ready,
  input  logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   overflow
);

  state_t            state;
  logic              armed;
  logic              rd_busy;
  logic              accept;
  logic              wr_en;
  logic              do_swap;
  logic              at_last;
  logic [ADDR_W-1:0] wr_addr;

  // The first cycle after reset release keeps s_ready low before filling starts.
`ifdef PINGPONG_DROP_EN
  assign s_ready = armed && ((state == FILL) || (state == HOLD));
`else
  assign s_ready = armed && (state == FILL);
`endif

  assign accept      = s_valid && s_ready;
  assign wr_en       = accept && (state == FILL);
  assign frame_ready = rd_busy;

  always_comb begin
    // NOTE: default first so every path assigns do_swap; otherwise a latch is inferred.
    do_swap = 1'b0;
    case (state)
      SWAP:    do_swap = !rd_busy || frame_done;
      HOLD:    do_swap = frame_done;
      default: do_swap = 1'b0;
    endcase
  end

  pp_addr_counter #(
    .ADDR_W   (ADDR_W),
    .FRAME_LEN(FRAME_LEN)
  ) u_addr_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (wr_en),
    .clr    (do_swap),
    .addr   (wr_addr),
    .at_last(at_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      armed     <= 1'b0;
      rd_busy   <= 1'b0;
      switch    <= 1'b0;
      frame_cnt <= '0;
      fu_we     <= 1'b0;
      fu_addra  <= '0;
      dt_an     <= '0;
    end else begin
      armed <= 1'b1;
      fu_we <= wr_en;
      if (wr_en) begin
        fu_addra <= wr_addr;
        dt_an    <= s_data;
      end

      // A done pulse on the swap edge is a release and re-acquire: rd_busy stays set.
      if (do_swap) begin
        switch    <= ~switch;
        rd_busy   <= 1'b1;
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end else if (frame_done) begin
        rd_busy <= 1'b0;
      end

      case (state)
        FILL:    if (wr_en && at_last) state <= SWAP;
        SWAP:    state <= do_swap ? FILL : HOLD;
        HOLD:    if (do_swap) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

`ifdef PINGPONG_DROP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (accept && (state == HOLD)) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
